// File: rtl/universal_shifter_pkg.sv
// Shared definitions for the universal shifter: MODE encoding and FSM states.
package universal_shifter_pkg;

  // MODE operand encoding; both hold codes are kept so decoders can list them explicitly.
  typedef enum logic [2:0] {
    ModeHold    = 3'b000,
    ModeShl     = 3'b001,
    ModeShr     = 3'b010,
    ModeLoad    = 3'b011,
    ModeRol     = 3'b100,
    ModeRor     = 3'b101,
    ModeAsr     = 3'b110,
    ModeHoldAlt = 3'b111
  } mode_e;

  // Control FSM states: StIdle steps or accepts START, StRun executes a counted run.
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/usr_next_value.sv
// Combinational next-value logic for the universal shifter register.
// Ports:
//   q_i       current register contents
//   mode_i    operation select (mode_e encoding)
//   dsr_i     serial input entering at the LSB on shift-left
//   dsl_i     serial input entering at the MSB on shift-right
//   p_i       parallel load data
//   q_next_o  register value after applying mode_i
module usr_next_value
  import universal_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [2:0]       mode_i,
  input  logic             dsr_i,
  input  logic             dsl_i,
  input  logic [WIDTH-1:0] p_i,
  output logic [WIDTH-1:0] q_next_o
);

  always_comb begin
    q_next_o = q_i;
    case (mode_e'(mode_i))
      ModeShl:  q_next_o = {q_i[WIDTH-2:0], dsr_i};
      ModeShr:  q_next_o = {dsl_i, q_i[WIDTH-1:1]};
      ModeLoad: q_next_o = p_i;
      ModeRol:  q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      ModeRor:  q_next_o = {q_i[0], q_i[WIDTH-1:1]};
      ModeAsr:  q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      default:  q_next_o = q_i;
    endcase
  end

endmodule

// File: rtl/universal_shifter.sv
// Universal shift register with single-step operation and counted runs.
// Ports:
//   CLOCK          rising-edge clock
//   MR             asynchronous active-high reset
//   P              parallel load data
//   DSR / DSL      serial inputs for shift-left (LSB) / shift-right (MSB)
//   MODE           operation select (mode_e encoding)
//   START / ABORT  begin / cancel a counted run
//   COUNT          number of operations in a counted run
//   Q              register contents; SOUT_L = Q msb, SOUT_R = Q lsb
//   BUSY           high while a counted run executes
//   DONE           one-cycle pulse after the last operation of a run
//   REMAIN         operations still to execute in the current run
module universal_shifter
  import universal_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 4
) (
  input  logic             CLOCK,
  input  logic             MR,
  input  logic [WIDTH-1:0] P,
  input  logic             DSR,
  input  logic             DSL,
  input  logic [2:0]       MODE,
  input  logic             START,
  input  logic             ABORT,
  input  logic [CNTW-1:0]  COUNT,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT_L,
  output logic             SOUT_R,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNTW-1:0]  REMAIN
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNTW-1:0]  remain_q, remain_d;
  logic             done_q, done_d;

  logic [2:0]       op_mode;
  logic [WIDTH-1:0] q_next;

  // A run uses the mode captured at START; step mode follows MODE live.
  assign op_mode = (state_q == StRun) ? mode_q : MODE;

  usr_next_value #(
    .WIDTH (WIDTH)
  ) u_next_value (
    .q_i      (q_q),
    .mode_i   (op_mode),
    .dsr_i    (DSR),
    .dsl_i    (DSL),
    .p_i      (P),
    .q_next_o (q_next)
  );

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    mode_d   = mode_q;
    remain_d = remain_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // START wins over ABORT and suppresses the step operation on this edge.
        if (START) begin
          mode_d   = MODE;
          remain_d = COUNT;
          if (COUNT != '0) begin
            state_d = StRun;
          end else begin
            done_d = 1'b1;
          end
        end else begin
          q_d = q_next;
        end
      end
      StRun: begin
        // ABORT pre-empts the pending operation and never produces DONE.
        if (ABORT) begin
          state_d  = StIdle;
          remain_d = '0;
        end else begin
          q_d      = q_next;
          remain_d = remain_q - 1'b1;
          if (remain_q == CNTW'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK or posedge MR) begin
    if (MR) begin
      state_q  <= StIdle;
      q_q      <= '0;
      mode_q   <= '0;
      remain_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      mode_q   <= mode_d;
      remain_q <= remain_d;
      done_q   <= done_d;
    end
  end

  assign Q      = q_q;
  assign SOUT_L = q_q[WIDTH-1];
  assign SOUT_R = q_q[0];
  assign BUSY   = (state_q == StRun);
  assign DONE   = done_q;
  assign REMAIN = remain_q;

endmodule

// File: tb/tb_universal_shifter.sv
// Scoreboard bench for universal_shifter (WIDTH=8, CNTW=4).
module tb_universal_shifter;

  logic       CLOCK;
  logic       MR;
  logic [7:0] P;
  logic       DSR;
  logic       DSL;
  logic [2:0] MODE;
  logic       START;
  logic       ABORT;
  logic [3:0] COUNT;
  logic [7:0] Q;
  logic       SOUT_L;
  logic       SOUT_R;
  logic       BUSY;
  logic       DONE;
  logic [3:0] REMAIN;

  universal_shifter #(
    .WIDTH (8),
    .CNTW  (4)
  ) dut (
    .CLOCK  (CLOCK),
    .MR     (MR),
    .P      (P),
    .DSR    (DSR),
    .DSL    (DSL),
    .MODE   (MODE),
    .START  (START),
    .ABORT  (ABORT),
    .COUNT  (COUNT),
    .Q      (Q),
    .SOUT_L (SOUT_L),
    .SOUT_R (SOUT_R),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .REMAIN (REMAIN)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    string      tag;
    logic [7:0] q;
    logic       busy;
    logic       done;
    logic [3:0] remain;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [7:0] m_q;
  logic       m_run;
  logic [2:0] m_mode;
  logic [3:0] m_remain;
  logic       m_done;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_next(input logic [7:0] q, input logic [2:0] m,
                                          input logic dsr, input logic dsl,
                                          input logic [7:0] p);
    case (m)
      3'b001:  return {q[6:0], dsr};
      3'b010:  return {dsl, q[7:1]};
      3'b011:  return p;
      3'b100:  return {q[6:0], q[7]};
      3'b101:  return {q[0], q[7:1]};
      3'b110:  return {q[7], q[7:1]};
      default: return q;
    endcase
  endfunction

  task automatic model_reset();
    m_q      = 8'h00;
    m_run    = 1'b0;
    m_mode   = 3'b000;
    m_remain = 4'd0;
    m_done   = 1'b0;
  endtask

  // Drive one cycle of stimulus, predict the post-edge state, then compare after the edge.
  task automatic cyc(input string tag, input logic [2:0] mode, input logic [7:0] p,
                     input logic dsr, input logic dsl, input logic start, input logic abort,
                     input logic [3:0] count);
    exp_t e;
    MODE  = mode;
    P     = p;
    DSR   = dsr;
    DSL   = dsl;
    START = start;
    ABORT = abort;
    COUNT = count;
    m_done = 1'b0;
    if (!m_run) begin
      if (start) begin
        m_mode   = mode;
        m_remain = count;
        if (count != 4'd0) m_run = 1'b1;
        else m_done = 1'b1;
      end else begin
        m_q = ref_next(m_q, mode, dsr, dsl, p);
      end
    end else if (abort) begin
      m_run    = 1'b0;
      m_remain = 4'd0;
    end else begin
      m_q      = ref_next(m_q, m_mode, dsr, dsl, p);
      m_remain = m_remain - 4'd1;
      if (m_remain == 4'd0) begin
        m_run  = 1'b0;
        m_done = 1'b1;
      end
    end
    e.tag    = tag;
    e.q      = m_q;
    e.busy   = m_run;
    e.done   = m_done;
    e.remain = m_remain;
    sb.push_back(e);
    @(posedge CLOCK);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_eq({e.tag, "_q"}, 32'(Q), 32'(e.q));
      check_eq({e.tag, "_busy"}, 32'(BUSY), 32'(e.busy));
      check_eq({e.tag, "_done"}, 32'(DONE), 32'(e.done));
      check_eq({e.tag, "_remain"}, 32'(REMAIN), 32'(e.remain));
      check_eq({e.tag, "_soutl"}, 32'(SOUT_L), 32'(e.q[7]));
      check_eq({e.tag, "_soutr"}, 32'(SOUT_R), 32'(e.q[0]));
    end
  endtask

  initial begin
    MR    = 1'b1;
    P     = 8'h00;
    DSR   = 1'b0;
    DSL   = 1'b0;
    MODE  = 3'b000;
    START = 1'b0;
    ABORT = 1'b0;
    COUNT = 4'd0;
    model_reset();

    #3;
    check_eq("rst_q", 32'(Q), 32'h00);
    check_eq("rst_busy", 32'(BUSY), 32'd0);
    check_eq("rst_done", 32'(DONE), 32'd0);
    check_eq("rst_remain", 32'(REMAIN), 32'd0);
    #9;
    MR = 1'b0;

    // Step mode: load, shift-left with DSR=1, shift-right with DSL=0.
    cyc("st_load", 3'b011, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_eq("st_load_lit", 32'(Q), 32'hA5);
    cyc("st_shl", 3'b001, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    check_eq("st_shl_lit", 32'(Q), 32'h4B);
    cyc("st_shr", 3'b010, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_eq("st_shr_lit", 32'(Q), 32'h25);
    cyc("st_hold7", 3'b111, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

    // Counted rotate-left of 0x81 by 3; MODE/P/COUNT changes during the run are ignored.
    cyc("rol_ld", 3'b011, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc("rol_start", 3'b100, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
    check_eq("rol_start_lit", 32'(Q), 32'h81);
    cyc("rol_1", 3'b011, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9);
    check_eq("rol_1_lit", 32'(Q), 32'h03);
    cyc("rol_2", 3'b010, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_eq("rol_2_lit", 32'(Q), 32'h06);
    cyc("rol_3", 3'b000, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_eq("rol_3_lit", 32'(Q), 32'h0C);
    check_eq("rol_done_lit", 32'(DONE), 32'd1);
    cyc("rol_after", 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Counted ASR of 0x90 by 2, then a new START accepted while DONE is high.
    cyc("asr_ld", 3'b011, 8'h90, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc("asr_start", 3'b110, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
    cyc("asr_1", 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_eq("asr_1_lit", 32'(Q), 32'hC8);
    cyc("asr_2", 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_eq("asr_2_lit", 32'(Q), 32'hE4);
    cyc("dstart", 3'b001, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'd1);
    cyc("dstart_1", 3'b000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    check_eq("dstart_lit", 32'(Q), 32'hC9);
    cyc("dstart_end", 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Zero count: Q unchanged, no BUSY, DONE next cycle.
    cyc("zero_start", 3'b100, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    check_eq("zero_done_lit", 32'(DONE), 32'd1);
    check_eq("zero_busy_lit", 32'(BUSY), 32'd0);
    cyc("zero_after", 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // START with ABORT in IDLE behaves as START; live DSL sampled in a counted shift-right.
    cyc("sa_start", 3'b010, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 4'd2);
    cyc("sa_1", 3'b000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc("sa_2", 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Load in a counted run samples P live.
    cyc("ldr_start", 3'b011, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
    cyc("ldr_1", 3'b000, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc("ldr_2", 3'b000, 8'hD2, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_eq("ldr_lit", 32'(Q), 32'hD2);

    // Abort after one rotate-right of 0x01.
    cyc("ab_ld", 3'b011, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc("ab_start", 3'b101, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4);
    cyc("ab_1", 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc("ab_abort", 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    check_eq("ab_q_lit", 32'(Q), 32'h80);
    check_eq("ab_busy_lit", 32'(BUSY), 32'd0);
    check_eq("ab_remain_lit", 32'(REMAIN), 32'd0);
    cyc("ab_after", 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    // ABORT in IDLE has no effect on step mode.
    cyc("ab_idle", 3'b001, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);

    // Asynchronous reset mid-run at REMAIN=2.
    cyc("mr_ld", 3'b011, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc("mr_start", 3'b100, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4);
    cyc("mr_1", 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc("mr_2", 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    check_eq("mr_pre_remain", 32'(REMAIN), 32'd2);
    #2;
    MR = 1'b1;
    #1;
    check_eq("mr_async_q", 32'(Q), 32'h00);
    check_eq("mr_async_busy", 32'(BUSY), 32'd0);
    check_eq("mr_async_remain", 32'(REMAIN), 32'd0);
    check_eq("mr_async_done", 32'(DONE), 32'd0);
    model_reset();
    @(posedge CLOCK);
    #2;
    MR = 1'b0;
    cyc("mr_rel_1", 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc("mr_rel_2", 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    cyc("mr_rel_3", 3'b001, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
